// File: rtl/game_input_pkg.sv
// Shared constants, types and helpers for the multi-player direction input unit.
package game_input_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Rows are players, columns are up, right, down, left.
  localparam logic [7:0] KEYMAP [4][4] = '{
    '{8'h75, 8'h74, 8'h72, 8'h6B},
    '{8'h1D, 8'h23, 8'h1B, 8'h1C},
    '{8'h43, 8'h4B, 8'h42, 8'h3B},
    '{8'h75, 8'h74, 8'h72, 8'h6B}
  };
  localparam logic [3:0] KEY_EXT = 4'b0001;

  localparam int EVT_PLAYER_LSB = 6;
  localparam int EVT_PRESS_BIT  = 5;
  localparam int EVT_DIR_LSB    = 0;

  typedef enum logic [1:0] {
    PS2_IDLE,
    PS2_EXT,
    PS2_BRK,
    PS2_EXT_BRK
  } ps2_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] player;
    logic [1:0] bit_idx;
  } key_hit_t;

  function automatic key_hit_t decode_key(input logic ext, input logic [7:0] code);
    key_hit_t k;
    k = '0;
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 4; b++) begin
        if (KEYMAP[p][b] == code && KEY_EXT[p] == ext) begin
          k.hit     = 1'b1;
          k.player  = 2'(p);
          k.bit_idx = 2'(b);
        end
      end
    end
    return k;
  endfunction

  function automatic logic [2:0] priority_dir(input logic [3:0] held);
    if (held[0])      return DIR_UP;
    else if (held[1]) return DIR_RIGHT;
    else if (held[2]) return DIR_DOWN;
    else if (held[3]) return DIR_LEFT;
    else              return DIR_NONE;
  endfunction

  function automatic logic [7:0] make_event(input logic [1:0] player, input logic press,
                                            input logic [2:0] dir);
    logic [7:0] e;
    e = '0;
    e[EVT_PLAYER_LSB +: 2] = player;
    e[EVT_PRESS_BIT]       = press;
    e[EVT_DIR_LSB +: 3]    = dir;
    return e;
  endfunction

endpackage

// File: rtl/game_input_ctrl_switch_debouncer.sv
// One-bit switch synchroniser plus debouncer: the output follows the input only
// after DEBOUNCE_CYCLES consecutive cycles at the new level.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sw_stable <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      if (sync2_q == sw_stable) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        sw_stable <= sync2_q;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_input_ctrl.sv
// Multi-player direction input: PS/2 scancodes and switches merged into held masks,
// scanned into press/release events. Switch path built only with GAME_INPUT_SWITCH_EN.
module game_input_ctrl
  import game_input_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ps2_key_pressed,
  input  logic [7:0]               ps2_key_data,
  input  logic [4*NUM_PLAYERS-1:0] sw_dir,
  output logic [3*NUM_PLAYERS-1:0] dir_out,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [7:0]               evt_data,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int NBITS  = 4 * NUM_PLAYERS;
  localparam int SCAN_W = $clog2(NBITS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  ps2_state_t       state_q, state_d;
  logic             dec_valid, dec_ext, dec_make;
  key_hit_t         key;
  logic [NBITS-1:0] kbd_q, kbd_d;
  logic [NBITS-1:0] deb_mask;
  logic [NBITS-1:0] combined;
  logic [NBITS-1:0] rep_q;
  logic [2:0]       dir_q [NUM_PLAYERS];

  logic [SCAN_W-1:0] scan_idx;
  logic [1:0]        scan_player, scan_bit;
  logic              scan_diff, scan_press;
  logic [3:0]        held_rest;
  logic [2:0]        cur_dir, scan_code;
  logic [7:0]        evt_new;

  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           fifo_empty, fifo_full, pop, push_ok, drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PS2_IDLE;
      kbd_q   <= '0;
    end else begin
      state_q <= state_d;
      kbd_q   <= kbd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dec_valid = 1'b0;
    dec_ext   = 1'b0;
    dec_make  = 1'b0;
    if (ps2_key_pressed) begin
      unique case (state_q)
        PS2_IDLE: begin
          if (ps2_key_data == SC_EXT)      state_d = PS2_EXT;
          else if (ps2_key_data == SC_BRK) state_d = PS2_BRK;
          else begin
            dec_valid = 1'b1;
            dec_make  = 1'b1;
          end
        end
        PS2_EXT: begin
          if (ps2_key_data == SC_BRK) state_d = PS2_EXT_BRK;
          else begin
            dec_valid = 1'b1;
            dec_ext   = 1'b1;
            dec_make  = 1'b1;
            state_d   = PS2_IDLE;
          end
        end
        PS2_BRK: begin
          dec_valid = 1'b1;
          state_d   = PS2_IDLE;
        end
        PS2_EXT_BRK: begin
          dec_valid = 1'b1;
          dec_ext   = 1'b1;
          state_d   = PS2_IDLE;
        end
        default: state_d = PS2_IDLE;
      endcase
    end
  end

  // Keys belonging to absent players map past NBITS and so never match.
  always_comb begin
    key   = decode_key(dec_ext, ps2_key_data);
    kbd_d = kbd_q;
    for (int i = 0; i < NBITS; i++) begin
      if (dec_valid && key.hit && {key.player, key.bit_idx} == 4'(i)) kbd_d[i] = dec_make;
    end
  end

`ifdef GAME_INPUT_SWITCH_EN
  for (genvar i = 0; i < NBITS; i++) begin : g_deb
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock     (clock),
      .reset     (reset),
      .sw_raw    (sw_dir[i]),
      .sw_stable (deb_mask[i])
    );
  end
`else
  logic unused_cfg;
  assign deb_mask   = '0;
  assign unused_cfg = ^{sw_dir, 32'(DEBOUNCE_CYCLES)};
`endif

  assign combined = kbd_q | deb_mask;

  always_comb begin
    scan_player = 2'(scan_idx >> 2);
    scan_bit    = scan_idx[1:0];
    scan_diff   = combined[scan_idx] != rep_q[scan_idx];
    scan_press  = combined[scan_idx];
    scan_code   = {1'b0, scan_bit} + 3'd1;
    held_rest   = '0;
    cur_dir     = DIR_NONE;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (scan_player == 2'(p)) begin
        held_rest = rep_q[4*p +: 4];
        cur_dir   = dir_q[p];
      end
    end
    held_rest[scan_bit] = 1'b0;
    evt_new = make_event(scan_player, scan_press, scan_code);
  end

  // The reported mask tracks the combined mask even when the event is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_idx <= '0;
      rep_q    <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) dir_q[p] <= DIR_NONE;
    end else begin
      scan_idx <= (scan_idx == SCAN_W'(NBITS - 1)) ? '0 : scan_idx + 1'b1;
      if (scan_diff) begin
        rep_q[scan_idx] <= scan_press;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (scan_player == 2'(p)) begin
            if (scan_press)                dir_q[p] <= scan_code;
            else if (cur_dir == scan_code) dir_q[p] <= priority_dir(held_rest);
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_dir
    assign dir_out[3*p +: 3] = dir_q[p];
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign evt_valid  = !fifo_empty;
  assign evt_data   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[PTR_W-1:0]];
  assign pop        = evt_valid & evt_ready;
  assign push_ok    = scan_diff && (!fifo_full || pop);
  assign drop       = scan_diff && fifo_full && !pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr[PTR_W-1:0]] <= evt_new;
  end

endmodule

// File: tb/tb_game_input_ctrl.sv
// Bench for game_input_ctrl: directed vector table, randomized keys against a reference
// model, overflow, reset mid-sequence, and (with GAME_INPUT_SWITCH_EN) switch debounce.
module tb_game_input_ctrl;

  localparam int NP = 2;
  localparam int DC = 1000;
  localparam int FD = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          ps2_key_pressed;
  logic [7:0]    ps2_key_data;
  logic [4*NP-1:0] sw_dir;
  logic [3*NP-1:0] dir_out;
  logic          evt_valid;
  logic          evt_ready;
  logic [7:0]    evt_data;
  logic          overflow;
  logic          overflow_clr;

  int checks = 0;
  int passes = 0;

  logic [7:0] key_code [4][4] = '{
    '{8'h75, 8'h74, 8'h72, 8'h6B},
    '{8'h1D, 8'h23, 8'h1B, 8'h1C},
    '{8'h43, 8'h4B, 8'h42, 8'h3B},
    '{8'h75, 8'h74, 8'h72, 8'h6B}
  };

  logic [3:0] ref_held [4];
  logic [2:0] ref_dir  [4];

  typedef struct {
    int         p;
    int         b;
    bit         make;
    bit         has;
    logic [7:0] ev;
    logic [2:0] d0;
    logic [2:0] d1;
  } vec_t;

  vec_t vecs [13];

  always #5 clock = ~clock;

  game_input_ctrl #(.NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(FD)) dut (
    .clock           (clock),
    .reset           (reset),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .sw_dir          (sw_dir),
    .dir_out         (dir_out),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_data        (evt_data),
    .overflow        (overflow),
    .overflow_clr    (overflow_clr)
  );

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ps2_key_pressed = 1'b0;
    ps2_key_data = 8'h00;
    sw_dir = '0;
    evt_ready = 1'b0;
    overflow_clr = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    for (int p = 0; p < 4; p++) begin
      ref_held[p] = 4'h0;
      ref_dir[p] = 3'd0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    ps2_key_pressed = 1'b1;
    ps2_key_data = b;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_key(input int p, input int b, input bit make);
    if (p == 0) send_byte(8'hE0);
    if (!make) send_byte(8'hF0);
    send_byte(key_code[p][b]);
  endtask

  // Reference: held set per player, last press wins, release of the current
  // direction falls back to the highest-priority key still held.
  task automatic model_key(input int p, input int b, input bit make,
                           output bit has_evt, output logic [7:0] ev);
    has_evt = 1'b0;
    ev = 8'h00;
    if (p >= NP) return;
    if (ref_held[p][b] == make) return;
    ref_held[p][b] = make;
    has_evt = 1'b1;
    ev = {2'(p), make, 2'b00, 3'(b + 1)};
    if (make) ref_dir[p] = 3'(b + 1);
    else if (ref_dir[p] == 3'(b + 1)) begin
      ref_dir[p] = 3'd0;
      for (int k = 3; k >= 0; k--) if (ref_held[p][k]) ref_dir[p] = 3'(k + 1);
    end
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(negedge clock);
    evt_ready = 1'b0;
  endtask

  task automatic apply_stimulus(input string tag, input int p, input int b, input bit make,
                                input bit has, input logic [7:0] ev,
                                input logic [2:0] d0, input logic [2:0] d1);
    send_key(p, b, make);
    tick(14);
    if (has) begin
      check_output({tag, "_valid"}, evt_valid, 1);
      check_output({tag, "_data"}, evt_data, ev);
      pop_one();
    end
    check_output({tag, "_empty"}, evt_valid, 0);
    check_output({tag, "_dir0"}, dir_out[2:0], d0);
    check_output({tag, "_dir1"}, dir_out[5:3], d1);
  endtask

  initial begin
    bit         has;
    logic [7:0] ev;
    logic [7:0] exp_ovf [8];
    bit         seen;
    int         lat;

    vecs[0]  = '{0, 0, 1'b1, 1'b1, 8'h21, 3'd1, 3'd0};
    vecs[1]  = '{0, 0, 1'b0, 1'b1, 8'h01, 3'd0, 3'd0};
    vecs[2]  = '{1, 0, 1'b1, 1'b1, 8'h61, 3'd0, 3'd1};
    vecs[3]  = '{1, 1, 1'b1, 1'b1, 8'h62, 3'd0, 3'd2};
    vecs[4]  = '{1, 1, 1'b0, 1'b1, 8'h42, 3'd0, 3'd1};
    vecs[5]  = '{1, 0, 1'b1, 1'b0, 8'h00, 3'd0, 3'd1};
    vecs[6]  = '{1, 0, 1'b0, 1'b1, 8'h41, 3'd0, 3'd0};
    vecs[7]  = '{2, 0, 1'b1, 1'b0, 8'h00, 3'd0, 3'd0};
    vecs[8]  = '{3, 0, 1'b1, 1'b0, 8'h00, 3'd0, 3'd0};
    vecs[9]  = '{0, 3, 1'b1, 1'b1, 8'h24, 3'd4, 3'd0};
    vecs[10] = '{0, 1, 1'b1, 1'b1, 8'h22, 3'd2, 3'd0};
    vecs[11] = '{0, 3, 1'b0, 1'b1, 8'h04, 3'd2, 3'd0};
    vecs[12] = '{0, 1, 1'b0, 1'b1, 8'h02, 3'd0, 3'd0};

    do_reset();
    check_output("reset_valid", evt_valid, 0);
    check_output("reset_data", evt_data, 8'h00);
    check_output("reset_dir", dir_out, 0);
    check_output("reset_overflow", overflow, 0);

    for (int i = 0; i < 13; i++) begin
      model_key(vecs[i].p, vecs[i].b, vecs[i].make, has, ev);
      apply_stimulus($sformatf("vec%0d", i), vecs[i].p, vecs[i].b, vecs[i].make,
                     vecs[i].has, vecs[i].ev, vecs[i].d0, vecs[i].d1);
    end

    for (int i = 0; i < 80; i++) begin
      int p, b;
      bit mk;
      p = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      mk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        send_byte(8'h29);
        tick(14);
        check_output($sformatf("rnd%0d_unmapped", i), evt_valid, 0);
      end else begin
        model_key(p, b, mk, has, ev);
        apply_stimulus($sformatf("rnd%0d", i), p, b, mk, has, ev, ref_dir[0], ref_dir[1]);
      end
    end

    do_reset();
    for (int i = 0; i < 8; i++) begin
      model_key(i / 4, i % 4, 1'b1, has, exp_ovf[i]);
      send_key(i / 4, i % 4, 1'b1);
      tick(14);
    end
    check_output("ovf_before_drop", overflow, 0);
    model_key(0, 0, 1'b0, has, ev);
    send_key(0, 0, 1'b0);
    tick(14);
    check_output("ovf_set", overflow, 1);
    check_output("ovf_dir0", dir_out[2:0], ref_dir[0]);
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("ovf_pop%0d_valid", i), evt_valid, 1);
      check_output($sformatf("ovf_pop%0d_data", i), evt_data, exp_ovf[i]);
      pop_one();
    end
    check_output("ovf_ninth_lost", evt_valid, 0);
    check_output("ovf_sticky", overflow, 1);
    overflow_clr = 1'b1;
    @(negedge clock);
    overflow_clr = 1'b0;
    check_output("ovf_cleared", overflow, 0);

    do_reset();
    send_byte(8'hF0);
    do_reset();
    send_byte(8'hE0);
    send_byte(8'h75);
    tick(14);
    check_output("midrst_valid", evt_valid, 1);
    check_output("midrst_data", evt_data, 8'h21);
    check_output("midrst_dir0", dir_out[2:0], 3'd1);
    pop_one();

    do_reset();
`ifdef GAME_INPUT_SWITCH_EN
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sw_dir[0] = (i % 2 == 0);
      for (int c = 0; c < 100; c++) begin
        @(negedge clock);
        if (evt_valid) seen = 1'b1;
      end
    end
    check_output("sw_bounce_quiet", seen, 0);
    sw_dir[0] = 1'b1;
    lat = 0;
    while (!evt_valid && lat < 1200) begin
      @(negedge clock);
      lat++;
    end
    check_output("sw_event_seen", evt_valid, 1);
    check_output("sw_event_data", evt_data, 8'h21);
    check_output("sw_latency_ok", (lat >= 1000 && lat <= 1020), 1);
    check_output("sw_dir0", dir_out[2:0], 3'd1);
    pop_one();
    tick(20);
    check_output("sw_single_event", evt_valid, 0);
`else
    seen = 1'b0;
    lat = 0;
    sw_dir = '1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (evt_valid) seen = 1'b1;
    end
    check_output("sw_ignored_evt", seen, 0);
    check_output("sw_ignored_dir", dir_out, lat);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
